// File: rtl/udp_tx_frame_builder.sv
// Byte-serial Ethernet/IPv4/UDP frame builder feeding a MAC TX AXI-Stream port.
// Header and opcode are generated internally; payload is drained from an FWFT FIFO.
module udp_tx_frame_builder #(
  parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_50,
  parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP   = {8'd192, 8'd168, 8'd1, 8'd50},
  parameter logic [31:0] DST_IP   = {8'd192, 8'd168, 8'd1, 8'd100},
  parameter logic [15:0] SRC_PORT = 16'd55556,
  parameter logic [15:0] DST_PORT = 16'd55555,
  parameter int unsigned MAX_LEN  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [10:0] tx_len,
  input  logic [11:0] tx_index,
  output logic        tx_busy,
  output logic        tx_err,
  input  logic [7:0]  fifo_dout,
  input  logic [10:0] fifo_count,
  output logic        fifo_rd_en,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam int unsigned CNT_W    = 11;
  localparam int unsigned ID_W     = 16;
  localparam int unsigned ACC_W    = 32;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(44);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(59);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    CSUM,
    HDR,
    PAYLOAD,
    PAD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [11:0]        idx_q, idx_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         cyc_q, cyc_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [7:0]         data_q, data_d;

  logic [15:0]        tot_len, udp_len;
  logic [CNT_W-1:0]   pay_end, last_idx, cnt_inc;
  logic               hs, len_ok;
  logic [ACC_W-1:0]   hdr_sum;
  logic [7:0]         hdr_next, hdr_first;

  // Header byte at position i; the checksum field comes from the folded accumulator.
  function automatic logic [7:0] hdr_byte(input logic [10:0] i,
                                          input logic [15:0] tot,
                                          input logic [15:0] id,
                                          input logic [15:0] cs,
                                          input logic [15:0] udp,
                                          input logic [11:0] idx);
    int k;
    k = int'(i);
    hdr_byte = 8'h00;
    if (k < 6)                 hdr_byte = 8'(DST_MAC >> (8 * (5 - k)));
    else if (k < 12)           hdr_byte = 8'(SRC_MAC >> (8 * (11 - k)));
    else if (k >= 26 && k < 30) hdr_byte = 8'(SRC_IP >> (8 * (29 - k)));
    else if (k >= 30 && k < 34) hdr_byte = 8'(DST_IP >> (8 * (33 - k)));
    else begin
      case (k)
        12:      hdr_byte = 8'h08;
        14:      hdr_byte = 8'h45;
        16:      hdr_byte = tot[15:8];
        17:      hdr_byte = tot[7:0];
        18:      hdr_byte = id[15:8];
        19:      hdr_byte = id[7:0];
        20:      hdr_byte = 8'h40;
        22:      hdr_byte = 8'h40;
        23:      hdr_byte = 8'h11;
        24:      hdr_byte = cs[15:8];
        25:      hdr_byte = cs[7:0];
        34:      hdr_byte = SRC_PORT[15:8];
        35:      hdr_byte = SRC_PORT[7:0];
        36:      hdr_byte = DST_PORT[15:8];
        37:      hdr_byte = DST_PORT[7:0];
        38:      hdr_byte = udp[15:8];
        39:      hdr_byte = udp[7:0];
        42:      hdr_byte = 8'hFE;
        43:      hdr_byte = {4'hD, idx[11:8]};
        44:      hdr_byte = idx[7:0];
        default: hdr_byte = 8'h00;
      endcase
    end
  endfunction

  assign tot_len  = 16'(len_q) + 16'd31;
  assign udp_len  = 16'(len_q) + 16'd11;
  assign pay_end  = len_q + HDR_LAST;
  assign last_idx = (pay_end < MIN_LAST) ? MIN_LAST : pay_end;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign hs       = valid_q & m_axis_tready;
  assign len_ok   = (tx_len != 11'd0) && (32'(tx_len) <= MAX_LEN);

  // Ten header words with the checksum word taken as zero.
  assign hdr_sum = 32'h0000_4500 + 32'(tot_len) + 32'(id_q) + 32'h0000_4000 +
                   32'h0000_4011 + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) +
                   32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);

  assign hdr_next  = hdr_byte(cnt_inc, tot_len, id_q, acc_q[15:0], udp_len, idx_q);
  assign hdr_first = hdr_byte(CNT_W'(0), tot_len, id_q, acc_q[15:0], udp_len, idx_q);

  assign tx_busy       = busy_q;
  assign tx_err        = err_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  // Payload bytes pass straight from the FWFT head so each pop exposes the next byte.
  assign m_axis_tdata  = (state_q == PAYLOAD) ? fifo_dout : data_q;
  assign fifo_rd_en    = (state_q == PAYLOAD) & valid_q & m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      id_q    <= '0;
      acc_q   <= '0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    id_d    = id_q;
    acc_d   = acc_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          if (len_ok) begin
            len_d   = tx_len;
            idx_d   = tx_index;
            busy_d  = 1'b1;
            state_d = WAIT_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // Whole payload must be buffered so tvalid never drops mid-frame.
      WAIT_DATA: begin
        if (fifo_count >= len_q) begin
          state_d = CSUM;
          cyc_d   = 2'd0;
        end
      end
      CSUM: begin
        cyc_d = cyc_q + 2'd1;
        case (cyc_q)
          2'd0:    acc_d = hdr_sum;
          2'd1,
          2'd2:    acc_d = {16'h0000, acc_q[15:0]} + {16'h0000, acc_q[31:16]};
          default: begin
            acc_d   = {16'h0000, ~acc_q[15:0]};
            state_d = HDR;
            cnt_d   = '0;
            valid_d = 1'b1;
            last_d  = 1'b0;
            data_d  = hdr_first;
          end
        endcase
      end
      HDR: begin
        if (hs) begin
          cnt_d = cnt_inc;
          if (cnt_q == HDR_LAST) begin
            state_d = PAYLOAD;
            data_d  = 8'h00;
          end else begin
            data_d = hdr_next;
          end
        end
      end
      PAYLOAD, PAD: begin
        if (hs) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            data_d  = 8'h00;
            id_d    = id_q + ID_W'(1);
          end else begin
            cnt_d  = cnt_inc;
            last_d = (cnt_inc == last_idx);
            if (state_q == PAYLOAD && cnt_q == pay_end) begin
              state_d = PAD;
              data_d  = 8'h00;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_frame_builder.sv
// Directed bench for udp_tx_frame_builder with an FWFT FIFO model and stream monitor.
module tb_udp_tx_frame_builder;

  logic        clk;
  logic        rst;
  logic        tx_start;
  logic [10:0] tx_len;
  logic [11:0] tx_index;
  logic        tx_busy;
  logic        tx_err;
  logic [7:0]  fifo_dout;
  logic [10:0] fifo_count;
  logic        fifo_rd_en;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;

  int asserts = 0;
  int fails   = 0;

  logic [7:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic do_pop = 1'b0;

  logic [7:0] cap   [0:1199];
  logic [7:0] exp_b [0:1199];
  int cap_n = 0, last_pos = -1, pops = 0, bad_pop = 0, stall_err = 0, stalls = 0, err_seen = 0;
  bit frame_done = 0;
  bit stall_prev = 0;
  logic [7:0] prev_data = 8'h00;
  logic prev_last = 1'b0;
  bit bp_en = 0;

  udp_tx_frame_builder dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len), .tx_index(tx_index),
    .tx_busy(tx_busy), .tx_err(tx_err), .fifo_dout(fifo_dout), .fifo_count(fifo_count),
    .fifo_rd_en(fifo_rd_en), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fifo_dout  = mem[rd_ptr[10:0]];
  assign fifo_count = 11'(wr_ptr - rd_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (do_pop) rd_ptr <= rd_ptr + 1;
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) m_axis_tready = ($urandom_range(0, 1) == 1);
    else       m_axis_tready = 1'b1;
  end

  // Stream monitor: captures handshakes, pops and stall stability between edges.
  always @(negedge clk) begin
    do_pop <= fifo_rd_en;
    if (!rst) begin
      if (fifo_rd_en) begin
        pops++;
        if (!(m_axis_tvalid && m_axis_tready)) bad_pop++;
      end
      if (stall_prev && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        stall_err++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      if (stall_prev) stalls++;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        cap[cap_n] = m_axis_tdata;
        if (m_axis_tlast) begin
          last_pos   = cap_n;
          frame_done = 1;
        end
        cap_n++;
      end
      if (tx_err) err_seen++;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[10:0]] = 8'(base + 8'(i));
      wr_ptr++;
    end
  endtask

  task automatic clear_cap();
    cap_n = 0; last_pos = -1; pops = 0; bad_pop = 0;
    stall_err = 0; stalls = 0; err_seen = 0; frame_done = 0;
  endtask

  task automatic start_frame(input int n, input logic [11:0] idx);
    @(posedge clk);
    #1;
    tx_len   = 11'(n);
    tx_index = idx;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t = 0;
    while (!frame_done && t < 3000) begin
      tick();
      t++;
    end
    ok = frame_done;
  endtask

  // Expected frame from literal header bytes; length fields and checksum are passed in.
  function automatic int build_exp(input int n, input logic [11:0] idx, input logic [15:0] id,
                                   input logic [15:0] tot, input logic [15:0] udp,
                                   input logic [15:0] cs, input logic [7:0] base);
    int len;
    for (int i = 0; i < 6; i++) exp_b[i] = 8'hFF;
    exp_b[6] = 8'h02; exp_b[7] = 8'h00; exp_b[8] = 8'h00; exp_b[9] = 8'h00;
    exp_b[10] = 8'h00; exp_b[11] = 8'h50; exp_b[12] = 8'h08; exp_b[13] = 8'h00;
    exp_b[14] = 8'h45; exp_b[15] = 8'h00; exp_b[16] = tot[15:8]; exp_b[17] = tot[7:0];
    exp_b[18] = id[15:8]; exp_b[19] = id[7:0]; exp_b[20] = 8'h40; exp_b[21] = 8'h00;
    exp_b[22] = 8'h40; exp_b[23] = 8'h11; exp_b[24] = cs[15:8]; exp_b[25] = cs[7:0];
    exp_b[26] = 8'hC0; exp_b[27] = 8'hA8; exp_b[28] = 8'h01; exp_b[29] = 8'h32;
    exp_b[30] = 8'hC0; exp_b[31] = 8'hA8; exp_b[32] = 8'h01; exp_b[33] = 8'h64;
    exp_b[34] = 8'hD9; exp_b[35] = 8'h04; exp_b[36] = 8'hD9; exp_b[37] = 8'h03;
    exp_b[38] = udp[15:8]; exp_b[39] = udp[7:0]; exp_b[40] = 8'h00; exp_b[41] = 8'h00;
    exp_b[42] = 8'hFE; exp_b[43] = {4'hD, idx[11:8]}; exp_b[44] = idx[7:0];
    for (int i = 0; i < n; i++) exp_b[45 + i] = 8'(base + 8'(i));
    len = 45 + n;
    while (len < 60) begin
      exp_b[len] = 8'h00;
      len++;
    end
    return len;
  endfunction

  function automatic int first_diff(input int len);
    for (int i = 0; i < len; i++)
      if (cap[i] !== exp_b[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tx_start = 1'b0; tx_len = '0; tx_index = '0;
    repeat (3) tick();
    asserts++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, tx_busy, tx_err, fifo_rd_en} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tdata, tx_busy, tx_err, fifo_rd_en});
    end
    rst = 1'b0;
    repeat (2) tick();
    asserts++;
    if ({m_axis_tvalid, tx_busy, tx_err} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b expected 000", {m_axis_tvalid, tx_busy, tx_err});
    end
  endtask

  task automatic test_basic_frame();
    int len, lat, d;
    bit ok;
    clear_cap();
    push_bytes(8'h00, 16);
    len = build_exp(16, 12'h123, 16'h0000, 16'h002F, 16'h001B, 16'hB6D7, 8'h00);
    start_frame(16, 12'h123);
    tick();
    asserts++;
    if (tx_busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy: got busy=%b tvalid=%b expected 1/0", tx_busy, m_axis_tvalid);
    end
    lat = 1;
    while (!m_axis_tvalid && lat < 40) begin
      tick();
      lat++;
    end
    asserts++;
    if (lat != 6) begin fails++; $display("FAIL basic_latency: got %0d expected 6", lat); end
    wait_done(ok);
    asserts++;
    if (!ok) begin fails++; $display("FAIL basic_done: got timeout expected tlast"); end
    asserts++;
    if (cap_n != len) begin fails++; $display("FAIL basic_length: got %0d expected %0d", cap_n, len); end
    d = first_diff(len);
    asserts++;
    if (d != -1) begin
      fails++;
      $display("FAIL basic_bytes: byte %0d got %h expected %h", d, cap[d], exp_b[d]);
    end
    asserts++;
    if ({cap[16], cap[17]} !== 16'h002F) begin
      fails++; $display("FAIL basic_total_len: got %h expected 002f", {cap[16], cap[17]});
    end
    asserts++;
    if ({cap[24], cap[25]} !== 16'hB6D7) begin
      fails++; $display("FAIL basic_checksum: got %h expected b6d7", {cap[24], cap[25]});
    end
    asserts++;
    if ({cap[38], cap[39]} !== 16'h001B) begin
      fails++; $display("FAIL basic_udp_len: got %h expected 001b", {cap[38], cap[39]});
    end
    asserts++;
    if ({cap[42], cap[43], cap[44]} !== 24'hFED123) begin
      fails++; $display("FAIL basic_opcode: got %h expected fed123", {cap[42], cap[43], cap[44]});
    end
    asserts++;
    if (last_pos != 60) begin fails++; $display("FAIL basic_tlast: got %0d expected 60", last_pos); end
    tick();
    asserts++;
    if (pops != 16) begin fails++; $display("FAIL basic_pops: got %0d expected 16", pops); end
    asserts++;
    if (tx_busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end: got %b expected 0", tx_busy); end
  endtask

  task automatic test_pad();
    int len, d, nz;
    bit ok;
    clear_cap();
    push_bytes(8'hA0, 4);
    len = build_exp(4, 12'h005, 16'h0001, 16'h0023, 16'h000F, 16'hB6E2, 8'hA0);
    start_frame(4, 12'h005);
    wait_done(ok);
    tick();
    asserts++;
    if (!ok || cap_n != 60) begin
      fails++; $display("FAIL pad_length: got %0d expected 60", cap_n);
    end
    d = first_diff(len);
    asserts++;
    if (d != -1) begin
      fails++; $display("FAIL pad_bytes: byte %0d got %h expected %h", d, cap[d], exp_b[d]);
    end
    nz = 0;
    for (int i = 49; i < 60; i++) if (cap[i] !== 8'h00) nz++;
    asserts++;
    if (nz != 0) begin fails++; $display("FAIL pad_zeros: got %0d nonzero expected 0", nz); end
    asserts++;
    if ({cap[16], cap[17]} !== 16'h0023) begin
      fails++; $display("FAIL pad_total_len: got %h expected 0023", {cap[16], cap[17]});
    end
    asserts++;
    if (last_pos != 59) begin fails++; $display("FAIL pad_tlast: got %0d expected 59", last_pos); end
    asserts++;
    if (pops != 4) begin fails++; $display("FAIL pad_pops: got %0d expected 4", pops); end
  endtask

  task automatic test_backpressure();
    int len, d;
    bit ok;
    clear_cap();
    bp_en = 1;
    push_bytes(8'h00, 16);
    len = build_exp(16, 12'h123, 16'h0002, 16'h002F, 16'h001B, 16'hB6D5, 8'h00);
    start_frame(16, 12'h123);
    wait_done(ok);
    tick();
    bp_en = 0;
    asserts++;
    if (!ok || cap_n != len) begin
      fails++; $display("FAIL bp_length: got %0d expected %0d", cap_n, len);
    end
    d = first_diff(len);
    asserts++;
    if (d != -1) begin
      fails++; $display("FAIL bp_bytes: byte %0d got %h expected %h", d, cap[d], exp_b[d]);
    end
    asserts++;
    if (stall_err != 0 || stalls == 0) begin
      fails++; $display("FAIL bp_stall_stable: got %0d unstable of %0d stalls expected 0", stall_err, stalls);
    end
    asserts++;
    if (bad_pop != 0 || pops != 16) begin
      fails++; $display("FAIL bp_pops: got %0d pops %0d bad expected 16/0", pops, bad_pop);
    end
  endtask

  task automatic test_wait_data();
    int len, d, viol;
    bit ok;
    clear_cap();
    push_bytes(8'h40, 10);
    len = build_exp(16, 12'hABC, 16'h0003, 16'h002F, 16'h001B, 16'hB6D4, 8'h40);
    start_frame(16, 12'hABC);
    viol = 0;
    repeat (20) begin
      tick();
      if (m_axis_tvalid !== 1'b0 || tx_busy !== 1'b1) viol++;
    end
    asserts++;
    if (viol != 0) begin fails++; $display("FAIL wait_hold: got %0d bad cycles expected 0", viol); end
    push_bytes(8'h4A, 6);
    wait_done(ok);
    tick();
    asserts++;
    if (!ok || cap_n != len) begin
      fails++; $display("FAIL wait_length: got %0d expected %0d", cap_n, len);
    end
    d = first_diff(len);
    asserts++;
    if (d != -1) begin
      fails++; $display("FAIL wait_bytes: byte %0d got %h expected %h", d, cap[d], exp_b[d]);
    end
    asserts++;
    if (pops != 16) begin fails++; $display("FAIL wait_pops: got %0d expected 16", pops); end
  endtask

  task automatic test_len_errors();
    int viol;
    clear_cap();
    start_frame(0, 12'h111);
    tick();
    asserts++;
    if (tx_err !== 1'b1 || tx_busy !== 1'b0) begin
      fails++; $display("FAIL err_len0: got err=%b busy=%b expected 1/0", tx_err, tx_busy);
    end
    tick();
    asserts++;
    if (tx_err !== 1'b0) begin fails++; $display("FAIL err_len0_pulse: got %b expected 0", tx_err); end
    start_frame(1025, 12'h222);
    tick();
    asserts++;
    if (tx_err !== 1'b1 || tx_busy !== 1'b0) begin
      fails++; $display("FAIL err_len1025: got err=%b busy=%b expected 1/0", tx_err, tx_busy);
    end
    viol = 0;
    repeat (10) begin
      tick();
      if (m_axis_tvalid !== 1'b0 || tx_busy !== 1'b0) viol++;
    end
    asserts++;
    if (viol != 0 || err_seen != 2) begin
      fails++; $display("FAIL err_no_frame: got %0d bad cycles %0d err pulses expected 0/2", viol, err_seen);
    end
  endtask

  task automatic test_start_while_busy();
    int len, d, t, viol;
    bit ok;
    clear_cap();
    push_bytes(8'h60, 16);
    len = build_exp(16, 12'h7FF, 16'h0004, 16'h002F, 16'h001B, 16'hB6D3, 8'h60);
    start_frame(16, 12'h7FF);
    t = 0;
    while (cap_n < 20 && t < 200) begin tick(); t++; end
    start_frame(5, 12'h001);
    wait_done(ok);
    tick();
    asserts++;
    if (!ok || cap_n != len || err_seen != 0) begin
      fails++; $display("FAIL busy_ignore: got len %0d err %0d expected %0d/0", cap_n, err_seen, len);
    end
    d = first_diff(len);
    asserts++;
    if (d != -1) begin
      fails++; $display("FAIL busy_bytes: byte %0d got %h expected %h", d, cap[d], exp_b[d]);
    end
    viol = 0;
    repeat (10) begin
      tick();
      if (tx_busy !== 1'b0 || m_axis_tvalid !== 1'b0) viol++;
    end
    asserts++;
    if (viol != 0) begin fails++; $display("FAIL busy_no_second: got %0d bad cycles expected 0", viol); end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    clear_cap();
    push_bytes(8'h80, 16);
    start_frame(16, 12'h321);
    t = 0;
    while (cap_n < 30 && t < 200) begin tick(); t++; end
    rst = 1'b1;
    #1;
    asserts++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, tx_busy} !== 11'h0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %h expected 0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, tx_busy});
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    asserts++;
    if (last_pos != -1 || m_axis_tvalid !== 1'b0 || cap_n < 30) begin
      fails++; $display("FAIL rst_mid_abandon: got last %0d bytes %0d expected -1/>=30", last_pos, cap_n);
    end
  endtask

  task automatic test_back_to_back();
    int len, d;
    bit ok;
    clear_cap();
    push_bytes(8'hC0, 32);
    len = build_exp(16, 12'h123, 16'h0000, 16'h002F, 16'h001B, 16'hB6D7, 8'hC0);
    start_frame(16, 12'h123);
    wait_done(ok);
    asserts++;
    if (!ok || cap_n != len) begin
      fails++; $display("FAIL b2b_a_length: got %0d expected %0d", cap_n, len);
    end
    d = first_diff(len);
    asserts++;
    if (d != -1 || {cap[18], cap[19]} !== 16'h0000) begin
      fails++; $display("FAIL b2b_a_bytes: byte %0d id %h expected id 0000", d, {cap[18], cap[19]});
    end
    clear_cap();
    len = build_exp(16, 12'h456, 16'h0001, 16'h002F, 16'h001B, 16'hB6D6, 8'hD0);
    start_frame(16, 12'h456);
    tick();
    asserts++;
    if (tx_busy !== 1'b1) begin fails++; $display("FAIL b2b_b_accept: got %b expected 1", tx_busy); end
    wait_done(ok);
    tick();
    asserts++;
    if (!ok || cap_n != len) begin
      fails++; $display("FAIL b2b_b_length: got %0d expected %0d", cap_n, len);
    end
    d = first_diff(len);
    asserts++;
    if (d != -1 || {cap[18], cap[19]} !== 16'h0001) begin
      fails++; $display("FAIL b2b_b_bytes: byte %0d id %h expected id 0001", d, {cap[18], cap[19]});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_pad();
    test_backpressure();
    test_wait_data();
    test_len_errors();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/udp_tx_frame_builder.md
Name: udp_tx_frame_builder

Overview:
- TX counterpart of the RX UDP extractor: builds complete Ethernet/IPv4/UDP frames, byte-serial, for the MAC TX AXI-Stream input.
- Frame layout: fixed header, 3-byte opcode {FE, D|idx[11:8], idx[7:0]}, then payload bytes drained from a first-word-fall-through (FWFT) FIFO.
- Computes the IPv4 header checksum, pads runt frames to 60 bytes and increments the IP identification field per frame.
- The MAC appends the FCS.

Parameters:
SRC_MAC, 48'h02_00_00_00_00_50, FPGA source MAC
DST_MAC, 48'hFF_FF_FF_FF_FF_FF, host destination MAC
SRC_IP, {192,168,1,50}, FPGA IP
DST_IP, {192,168,1,100}, host IP
SRC_PORT, 16'd55556, UDP source port
DST_PORT, 16'd55555, UDP destination port (host script)
MAX_LEN, 1024, maximum payload bytes per frame

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous and active-high
tx_start  in  1  single-cycle request
tx_len  in  11  payload byte count N, sampled on accepted tx_start
tx_index  in  12  index for opcode, sampled on accepted tx_start
tx_busy  out  1  high from accepted tx_start through the final handshake
tx_err  out  1  one-cycle pulse when tx_start is rejected
fifo_dout  in  8  FWFT payload byte
fifo_count  in  11  bytes currently held in the FIFO
fifo_rd_en  out  1  pop; combinational = (state==PAYLOAD) & m_axis_tvalid & m_axis_tready
m_axis_tdata  out  8  frame byte
m_axis_tvalid  out  1  AXI-S valid
m_axis_tready  in  1  AXI-S ready
m_axis_tlast  out  1  high on the last frame byte

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE; tx_busy, tx_err, m_axis_tvalid, m_axis_tlast = 0; m_axis_tdata=0.
  - IP ID counter = 0.
  - A truncated frame is abandoned; no tlast is issued.
- tx_start handling:
  - Accepted only in IDLE with 1 <= tx_len <= MAX_LEN; latches N and the index, tx_busy <= 1 next cycle.
  - Invalid tx_len while in IDLE: tx_err pulses 1 cycle, state stays IDLE.
  - tx_start while busy: ignored, no tx_err.
- FSM: IDLE -> WAIT_DATA -> CSUM -> HDR -> PAYLOAD -> [PAD] -> IDLE.
  - WAIT_DATA: hold until fifo_count >= N. This guarantees no tvalid gaps mid-frame; tvalid stays 0 while waiting.
  - CSUM: exactly 4 cycles.
    - 32-bit accumulation of the 10 header words, with the checksum word taken as 0.
    - Fold carries twice, then invert.
    - total_len = 31+N; udp_len = 11+N.
  - HDR: bytes 0..44, MSB-first per field.
    - 0-5 DST_MAC, 6-11 SRC_MAC, 12-13 0x0800.
    - 14 0x45, 15 0x00, 16-17 total_len, 18-19 ID, 20-21 0x4000, 22 0x40, 23 0x11, 24-25 checksum.
    - 26-29 SRC_IP, 30-33 DST_IP, 34-35 SRC_PORT, 36-37 DST_PORT, 38-39 udp_len, 40-41 0x0000 (UDP checksum unused).
    - 42 0xFE, 43 {4'hD, idx[11:8]}, 44 idx[7:0].
  - PAYLOAD: bytes 45..44+N; tdata = fifo_dout, one pop per handshake.
  - PAD: entered only if 45+N < 60. Emits zero bytes up to byte 59. Padding is excluded from total_len and udp_len.
- tvalid behaviour:
  - Rises on the first cycle of HDR.
  - Stays high continuously until the last handshake.
  - tdata, tvalid and tlast are held stable while tvalid & !tready.
- tlast: high on byte max(44+N, 59) only.
- Latency: with data already present, first tvalid occurs 6 cycles after the tx_start cycle (1 accept, 1 WAIT_DATA, 4 CSUM).
- End of frame: after the tlast handshake, state=IDLE, tx_busy=0 and ID increments by 1 (16-bit wrap, 0xFFFF -> 0x0000). tx_start is accepted on the following cycle.
- Byte counter: 11 bits, ranges 0..1068, never wraps within a frame.

Test Plan:
- N=16, idx=0x123, ID=0, FIFO holds 0x00..0x0F, tready=1 -> 61 bytes.
  - Bytes 16-17 = 0x002F, 24-25 = 0xB6D7, 38-39 = 0x001B, 42-44 = FE D1 23.
  - Payload 0x00..0x0F; tlast on byte 60; exactly 16 pops.
- N=4 -> 60 bytes, bytes 49-59 = 0x00, total_len = 0x0023, tlast on byte 59, exactly 4 pops.
- N=16 with random tready backpressure -> byte stream identical to the first scenario; tdata is stable during every stall; no pop without a handshake.
- tx_start with fifo_count=10, N=16; refill to 16 after 20 cycles -> tvalid stays 0 until the refill; the frame is then correct; tx_busy is high throughout.
- tx_len=0 and tx_len=1025 -> tx_err pulses, no frame. tx_start mid-frame -> ignored. Two back-to-back frames -> ID fields 0x0000 then 0x0001.
- Assert rst at byte 30 of a frame -> outputs are 0 immediately; the next request produces a complete correct frame with ID=0x0000.
